// File: rtl/conv3x3_mac.sv
// conv3x3_mac: captures one multi-channel 3x3 window, then MACs it against every kernel in the buffer.
// Optional output ReLU is enabled by defining CONV3X3_MAC_RELU_EN.
module conv3x3_mac #(
    parameter int WIDTH        = 16,
    parameter int BUFFER_WIDTH = 64,
    parameter int BUFFER_DEPTH = 512,
    parameter int CH_GROUPS    = 4,
    parameter int ACC_WIDTH    = 48
) (
    input  logic                            i_aclk,
    input  logic                            i_areset,
    input  logic                            i_buf_valid,
    output logic [$clog2(BUFFER_DEPTH)-1:0] o_sel,
    input  logic [BUFFER_WIDTH-1:0]         i_buf_00,
    input  logic [BUFFER_WIDTH-1:0]         i_buf_01,
    input  logic [BUFFER_WIDTH-1:0]         i_buf_02,
    input  logic [BUFFER_WIDTH-1:0]         i_buf_10,
    input  logic [BUFFER_WIDTH-1:0]         i_buf_11,
    input  logic [BUFFER_WIDTH-1:0]         i_buf_12,
    input  logic [BUFFER_WIDTH-1:0]         i_buf_20,
    input  logic [BUFFER_WIDTH-1:0]         i_buf_21,
    input  logic [BUFFER_WIDTH-1:0]         i_buf_22,
    input  logic                            i_win_tvalid,
    output logic                            o_win_tready,
    input  logic [9*BUFFER_WIDTH-1:0]       i_win_tdata,
    output logic                            o_tvalid,
    input  logic                            i_tready,
    output logic [ACC_WIDTH-1:0]            o_tdata,
    output logic                            o_tlast
);
    localparam int LANES   = BUFFER_WIDTH / WIDTH;
    localparam int KERNELS = BUFFER_DEPTH / CH_GROUPS;
    localparam int SEL_W   = $clog2(BUFFER_DEPTH);
    localparam int KW      = (KERNELS > 1) ? $clog2(KERNELS) : 1;
    localparam int GW      = (CH_GROUPS > 1) ? $clog2(CH_GROUPS) : 1;
    localparam int CW      = $clog2(CH_GROUPS + 1);
    localparam int PW      = 2 * WIDTH;
    localparam int NPROD   = 9 * LANES;

    typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, OUT} state_t;

    state_t                 state_q, state_d;
    logic [GW-1:0]          g_q, g_d;
    logic [KW-1:0]          k_q, k_d;
    logic [CW-1:0]          iss_q, iss_d;
    logic [SEL_W-1:0]       sel_q, sel_d;
    logic [9*BUFFER_WIDTH-1:0] win_q [CH_GROUPS];
    logic [9*BUFFER_WIDTH-1:0] win_sel;
    logic [BUFFER_WIDTH-1:0]   buf_w [9];

    logic                   vld_p0_q, vld_p1_q, vld_p2_q;
    logic                   first_p0_q, first_p1_q, first_p2_q;
    logic                   last_p0_q, last_p1_q, last_p2_q;
    logic [GW-1:0]          grp_p0_q;
    logic signed [PW-1:0]   prod_p1_q [NPROD];
    logic signed [ACC_WIDTH-1:0] sum_c, sum_p2_q, acc_q, acc_next, tdata_q;

    logic win_hs, abort, issue, last_k, acc_done;

    function automatic logic signed [PW-1:0] mul_fn(input logic signed [WIDTH-1:0] a,
                                                    input logic signed [WIDTH-1:0] b);
        return PW'(a) * PW'(b);
    endfunction

    function automatic logic signed [ACC_WIDTH-1:0] relu_fn(input logic signed [ACC_WIDTH-1:0] v);
`ifdef CONV3X3_MAC_RELU_EN
        return v[ACC_WIDTH-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    assign buf_w[0] = i_buf_00;
    assign buf_w[1] = i_buf_01;
    assign buf_w[2] = i_buf_02;
    assign buf_w[3] = i_buf_10;
    assign buf_w[4] = i_buf_11;
    assign buf_w[5] = i_buf_12;
    assign buf_w[6] = i_buf_20;
    assign buf_w[7] = i_buf_21;
    assign buf_w[8] = i_buf_22;

    assign win_hs   = (state_q == LOAD) && i_win_tvalid;
    assign abort    = (state_q != IDLE) && !i_buf_valid;
    assign issue    = (state_q == COMPUTE) && (iss_q < CW'(CH_GROUPS));
    assign last_k   = (k_q == KW'(KERNELS - 1));
    assign acc_done = vld_p2_q && last_p2_q;
    assign win_sel  = win_q[grp_p0_q];
    assign acc_next = (first_p2_q ? '0 : acc_q) + sum_p2_q;

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        k_d     = k_q;
        iss_d   = iss_q;
        sel_d   = sel_q;
        if (issue) begin
            iss_d = iss_q + CW'(1);
            // o_sel stops on the last group of the kernel and holds through OUT
            if (iss_q != CW'(CH_GROUPS - 1)) begin
                sel_d = sel_q + SEL_W'(1);
            end
        end
        case (state_q)
            IDLE: begin
                if (i_buf_valid) begin
                    state_d = LOAD;
                    g_d     = '0;
                end
            end
            LOAD: begin
                if (win_hs) begin
                    if (g_q == GW'(CH_GROUPS - 1)) begin
                        state_d = COMPUTE;
                        g_d     = '0;
                        k_d     = '0;
                        iss_d   = '0;
                        sel_d   = '0;
                    end else begin
                        g_d = g_q + GW'(1);
                    end
                end
            end
            COMPUTE: begin
                if (acc_done) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                if (i_tready) begin
                    if (!last_k) begin
                        state_d = COMPUTE;
                        k_d     = k_q + KW'(1);
                        iss_d   = '0;
                        sel_d   = sel_q + SEL_W'(1);
                    end else begin
                        state_d = i_buf_valid ? LOAD : IDLE;
                        g_d     = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d = IDLE;
            g_d     = '0;
        end
    end

    always_ff @(posedge i_aclk) begin
        if (i_areset) begin
            state_q  <= IDLE;
            g_q      <= '0;
            k_q      <= '0;
            iss_q    <= '0;
            sel_q    <= '0;
            vld_p0_q <= 1'b0;
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            tdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            g_q      <= g_d;
            k_q      <= k_d;
            iss_q    <= iss_d;
            sel_q    <= sel_d;
            vld_p0_q <= issue && !abort;
            vld_p1_q <= vld_p0_q && !abort;
            vld_p2_q <= vld_p1_q && !abort;
            if (acc_done && !abort) begin
                tdata_q <= relu_fn(acc_next);
            end
        end
    end

    // p0: kernel word arriving from buffer | p1: lane products | p2: tree sum | then accumulate
    always_ff @(posedge i_aclk) begin
        if (win_hs) begin
            win_q[g_q] <= i_win_tdata;
        end
        first_p0_q <= (iss_q == '0);
        last_p0_q  <= (iss_q == CW'(CH_GROUPS - 1));
        grp_p0_q   <= GW'(iss_q);
        first_p1_q <= first_p0_q;
        last_p1_q  <= last_p0_q;
        first_p2_q <= first_p1_q;
        last_p2_q  <= last_p1_q;
        for (int p = 0; p < 9; p++) begin
            for (int l = 0; l < LANES; l++) begin
                prod_p1_q[p*LANES + l] <= mul_fn(win_sel[p*BUFFER_WIDTH + l*WIDTH +: WIDTH],
                                                 buf_w[p][l*WIDTH +: WIDTH]);
            end
        end
        sum_p2_q <= sum_c;
        if (vld_p2_q) begin
            acc_q <= acc_next;
        end
    end

    always_comb begin
        sum_c = '0;
        for (int i = 0; i < NPROD; i++) begin
            sum_c = sum_c + ACC_WIDTH'(prod_p1_q[i]);
        end
    end

    assign o_sel        = sel_q;
    assign o_win_tready = (state_q == LOAD);
    assign o_tvalid     = (state_q == OUT);
    assign o_tlast      = (state_q == OUT) && last_k;
    assign o_tdata      = tdata_q;

endmodule
